// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program-counter register with next-PC selection
// (sequential / branch / region jump / call / return) and a circular
// return-address stack with overflow and underflow pulse flags.
module pc_ras_unit #(
  parameter int              PC_W        = 16,
  parameter int              JMP_W       = 13,
  parameter int              INSTR_BYTES = 2,
  parameter int              RAS_DEPTH   = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic [1:0]                   pc_src,
  input  logic                         branch,
  input  logic                         zero,
  input  logic [PC_W-1:0]              ext_brn_imm,
  input  logic [JMP_W-1:0]             abs_jmp,
  output logic [PC_W-1:0]              pc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0]  PC_INC   = PC_W'(INSTR_BYTES);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_CALL = 2'b01;
  localparam logic [1:0] SRC_JMP  = 2'b10;
  localparam logic [1:0] SRC_RET  = 2'b11;

  if (PC_W < JMP_W + 2) begin : g_bad_jmp_w
    $error("pc_ras_unit: PC_W must be at least JMP_W+2");
  end
  if (RAS_DEPTH < 2 || (1 << PTR_W) != RAS_DEPTH) begin : g_bad_depth
    $error("pc_ras_unit: RAS_DEPTH must be a power of two >= 2");
  end

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PC_W-1:0]  ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [PC_W-1:0]  seq_pc;
  logic [PC_W-1:0]  jmp_pc;
  logic [PTR_W-1:0] top_dec;

  // Candidate targets; top_q points at the next free slot, so the newest
  // entry sits one below it (and a full stack's top_q is the oldest slot).
  always_comb begin
    seq_pc  = pc_q + PC_INC;
    jmp_pc  = {pc_q[PC_W-1:JMP_W+1], abs_jmp, 1'b0};
    top_dec = top_q - PTR_W'(1);
  end

  // Next-state selection for PC, stack, pointer, count and flags.
  always_comb begin
    pc_d  = pc_q;
    ras_d = ras_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (!stall) begin
      case (pc_src)
        SRC_SEQ: begin
          pc_d = (branch && zero) ? (seq_pc + ext_brn_imm) : seq_pc;
        end
        SRC_CALL: begin
          ras_d[top_q] = seq_pc;
          top_d        = top_q + PTR_W'(1);
          pc_d         = jmp_pc;
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SRC_JMP: begin
          pc_d = jmp_pc;
        end
        SRC_RET: begin
          if (cnt_q != '0) begin
            pc_d  = ras_q[top_dec];
            top_d = top_dec;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            pc_d  = seq_pc;
            unf_d = 1'b1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage needs no reset: entries are only read below a valid count.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: a vector table for reset, branch, jump
// and simple call/return, then hand sequences for stack wrap and stall.
module tb_pc_ras_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  pc_src;
  logic        branch;
  logic        zero;
  logic [15:0] ext_brn_imm;
  logic [12:0] abs_jmp;
  logic [15:0] pc;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  pc_ras_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch       (branch),
    .zero         (zero),
    .ext_brn_imm  (ext_brn_imm),
    .abs_jmp      (abs_jmp),
    .pc           (pc),
    .ras_count    (ras_count),
    .ras_overflow (ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic [1:0]  src;
    logic        br;
    logic        z;
    logic [15:0] imm;
    logic [12:0] abs;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic [1:0] src, logic br, logic z,
                              logic [15:0] imm, logic [12:0] abs, logic [15:0] e_pc,
                              logic [2:0] e_cnt, logic e_ovf, logic e_unf);
    vec_t v;
    v.rst_n = r;  v.stall = s; v.src = src; v.br = br; v.z = z;
    v.imm = imm;  v.abs = abs; v.e_pc = e_pc; v.e_cnt = e_cnt;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic chk(string tag, int idx, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%04h expected 0x%04h", tag, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, then check all outputs.
  task automatic step(int idx, logic r, logic s, logic [1:0] src, logic br, logic z,
                      logic [15:0] imm, logic [12:0] abs, logic [15:0] e_pc,
                      logic [2:0] e_cnt, logic e_ovf, logic e_unf);
    rst_n = r; stall = s; pc_src = src; branch = br; zero = z;
    ext_brn_imm = imm; abs_jmp = abs;
    @(posedge clk);
    #1;
    chk("pc",        idx, pc, e_pc);
    chk("ras_count", idx, {13'b0, ras_count}, {13'b0, e_cnt});
    chk("overflow",  idx, {15'b0, ras_overflow}, {15'b0, e_ovf});
    chk("underflow", idx, {15'b0, ras_underflow}, {15'b0, e_unf});
  endtask

  logic [15:0] exp_pc;
  logic [15:0] ret_q[$];
  logic [2:0]  exp_cnt;
  logic [12:0] a;

  initial begin
    rst_n = 1'b0; stall = 1'b1; pc_src = 2'b10; branch = 1'b0; zero = 1'b0;
    ext_brn_imm = '0; abs_jmp = '0;

    // reset wins over stall and jmp
    vecs.push_back(mk(0,1,2'b10,0,0,16'h0000,13'h0055,16'h0000,0,0,0));
    vecs.push_back(mk(0,1,2'b10,0,0,16'h0000,13'h0055,16'h0000,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0,16'h0000,13'h0000,16'h0002,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0,16'h0000,13'h0000,16'h0004,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,1,16'h0100,13'h0000,16'h0006,0,0,0));
    // jmp to 0x0010, taken backward branch, not-taken branch
    vecs.push_back(mk(1,0,2'b10,1,1,16'h0100,13'h0008,16'h0010,0,0,0));
    vecs.push_back(mk(1,0,2'b00,1,1,16'hFFF0,13'h0000,16'h0002,0,0,0));
    vecs.push_back(mk(1,0,2'b10,0,0,16'h0000,13'h0008,16'h0010,0,0,0));
    vecs.push_back(mk(1,0,2'b00,1,0,16'hFFF0,13'h0000,16'h0012,0,0,0));
    // branch into region 11, jmp to 0xFFFE, sequential wrap
    vecs.push_back(mk(1,0,2'b00,1,1,16'hC000,13'h0000,16'hC014,0,0,0));
    vecs.push_back(mk(1,0,2'b10,0,0,16'h0000,13'h1FFF,16'hFFFE,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0,16'h0000,13'h0000,16'h0000,0,0,0));
    // reach 0xC004, then region-preserving jmp
    vecs.push_back(mk(1,0,2'b00,1,1,16'hC000,13'h0000,16'hC002,0,0,0));
    vecs.push_back(mk(1,0,2'b00,0,0,16'h0000,13'h0000,16'hC004,0,0,0));
    vecs.push_back(mk(1,0,2'b10,0,0,16'h0000,13'h0123,16'hC246,0,0,0));
    // branch to 0x0100, call, return (branch/zero ignored on ret)
    vecs.push_back(mk(1,0,2'b00,1,1,16'h3EB8,13'h0000,16'h0100,0,0,0));
    vecs.push_back(mk(1,0,2'b01,0,0,16'h0000,13'h0400,16'h0800,1,0,0));
    vecs.push_back(mk(1,0,2'b11,1,1,16'h0040,13'h0000,16'h0102,0,0,0));

    for (int i = 0; i < vecs.size(); i++)
      step(i, vecs[i].rst_n, vecs[i].stall, vecs[i].src, vecs[i].br, vecs[i].z,
           vecs[i].imm, vecs[i].abs, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);

    // five calls: the fifth drops the oldest return address and flags overflow
    exp_pc = 16'h0102;
    for (int i = 0; i < 5; i++) begin
      a = 13'h0100 + 13'(i * 32);
      if (ret_q.size() == 4) void'(ret_q.pop_front());
      ret_q.push_back(exp_pc + 16'd2);
      exp_pc = {exp_pc[15:14], a, 1'b0};
      exp_cnt = 3'(ret_q.size());
      step(100 + i, 1, 0, 2'b01, 0, 0, 16'h0000, a, exp_pc, exp_cnt, (i == 4), 0);
    end
    // four returns come back newest first
    for (int i = 0; i < 4; i++) begin
      exp_pc = ret_q.pop_back();
      exp_cnt = 3'(ret_q.size());
      step(200 + i, 1, 0, 2'b11, 0, 0, 16'h0000, 13'h0000, exp_pc, exp_cnt, 0, 0);
    end
    // fifth return underflows and falls through; flag lasts one cycle
    exp_pc = exp_pc + 16'd2;
    step(204, 1, 0, 2'b11, 0, 0, 16'h0000, 13'h0000, exp_pc, 0, 0, 1);
    exp_pc = exp_pc + 16'd2;
    step(205, 1, 0, 2'b00, 0, 0, 16'h0000, 13'h0000, exp_pc, 0, 0, 0);

    // stall holds pc and stack, then reset during stall
    exp_pc = {exp_pc[15:14], 13'h0040, 1'b0};
    step(300, 1, 0, 2'b01, 0, 0, 16'h0000, 13'h0040, exp_pc, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(301 + i, 1, 1, 2'b01, 1, 1, 16'h0010, 13'h0777, exp_pc, 1, 0, 0);
    step(304, 1, 1, 2'b11, 0, 0, 16'h0000, 13'h0000, exp_pc, 1, 0, 0);
    step(305, 0, 1, 2'b01, 0, 0, 16'h0000, 13'h0777, 16'h0000, 0, 0, 0);
    // count really cleared: a return now underflows
    step(306, 1, 0, 2'b11, 0, 0, 16'h0000, 13'h0000, 16'h0002, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
